// File: rtl/pwl_cmd_bridge_if.sv
// Host/DUT signal bundle for pwl_cmd_bridge.
//   Host command stream : in_valid, in_ready, in_cmd, in_wdata, in_expect
//   DUT pins            : dut_cmd, dut_wdata (to DUT), dut_data, dut_ready (from DUT)
//   Response stream     : resp_valid, resp_ready, resp_data, resp_timeout
//   Status              : busy
// The slave modport is the bridge side and the master modport is the host/bench side.
interface pwl_cmd_bridge_if #(
  parameter int unsigned CMD_BITS  = 3,
  parameter int unsigned DATA_BITS = 13
);
  logic                 in_valid;
  logic                 in_ready;
  logic [CMD_BITS-1:0]  in_cmd;
  logic [DATA_BITS-1:0] in_wdata;
  logic                 in_expect;
  logic [CMD_BITS-1:0]  dut_cmd;
  logic [DATA_BITS-1:0] dut_wdata;
  logic [DATA_BITS-1:0] dut_data;
  logic                 dut_ready;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DATA_BITS-1:0] resp_data;
  logic                 resp_timeout;
  logic                 busy;

  modport slave (
    input  in_valid, in_cmd, in_wdata, in_expect, dut_data, dut_ready, resp_ready,
    output in_ready, dut_cmd, dut_wdata, resp_valid, resp_data, resp_timeout, busy
  );

  modport master (
    output in_valid, in_cmd, in_wdata, in_expect, dut_data, dut_ready, resp_ready,
    input  in_ready, dut_cmd, dut_wdata, resp_valid, resp_data, resp_timeout, busy
  );
endinterface

// File: rtl/pwl_cmd_bridge.sv
// Host-side bridge: buffers host commands in a FIFO, replays each onto the DUT
// command/data pins as a HOLD_CYCLES-wide pulse followed by a NOP cycle, and
// optionally waits (with timeout) for dut_ready, queuing responses in a FIFO.
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   br     - pwl_cmd_bridge_if.slave (host command stream, DUT pins,
//            response stream, busy)
module pwl_cmd_bridge #(
  parameter int unsigned CMD_BITS    = 3,
  parameter int unsigned DATA_BITS   = 13,
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned RESP_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  pwl_cmd_bridge_if.slave   br
);

  localparam int unsigned CP_W   = $clog2(CMD_DEPTH);
  localparam int unsigned RP_W   = $clog2(RESP_DEPTH);
  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned WAIT_W = 16;

  localparam logic [CP_W:0]       CQ_MAX    = CMD_DEPTH[CP_W:0];
  localparam logic [RP_W+1:0]     RQ_MAX    = RESP_DEPTH[RP_W+1:0];
  localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t state, state_nx;

  // Command FIFO
  logic [CMD_BITS-1:0]  cq_cmd  [CMD_DEPTH];
  logic [DATA_BITS-1:0] cq_wdata[CMD_DEPTH];
  logic                 cq_exp  [CMD_DEPTH];
  logic [CP_W-1:0]      cq_wr, cq_rd;
  logic [CP_W:0]        cq_cnt;
  logic                 cq_push, cq_pop, cq_full;

  // Response FIFO
  logic [DATA_BITS-1:0] rq_data[RESP_DEPTH];
  logic                 rq_to  [RESP_DEPTH];
  logic [RP_W-1:0]      rq_wr, rq_rd;
  logic [RP_W:0]        rq_cnt;
  logic [RP_W+1:0]      rq_used;
  logic                 rq_push, rq_pop, rq_push_to;
  logic [DATA_BITS-1:0] rq_push_data;

  // Issue datapath
  logic [CMD_BITS-1:0]  dut_cmd_q;
  logic [DATA_BITS-1:0] dut_wdata_q;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 cur_expect;
  logic                 reserved;
  logic                 head_ok;
  logic                 wait_done;

  assign cq_full = (cq_cnt == CQ_MAX);
  assign cq_push = br.in_valid && !cq_full;
  assign rq_pop  = (rq_cnt != '0) && br.resp_ready;

  // A response slot is claimed at pop time so a response can never find the FIFO full.
  assign rq_used   = {1'b0, rq_cnt} + {{(RP_W+1){1'b0}}, reserved};
  assign head_ok   = (cq_cnt != '0) && (!cq_exp[cq_rd] || (rq_used < RQ_MAX));
  assign wait_done = br.dut_ready || (wait_cnt == WAIT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (head_ok) state_nx = S_ISSUE;
      S_ISSUE: if (hold_cnt == '0) state_nx = cur_expect ? S_WAIT : S_IDLE;
      S_WAIT:  if (wait_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output / strobe logic
  always_comb begin
    cq_pop       = 1'b0;
    rq_push      = 1'b0;
    rq_push_to   = 1'b0;
    rq_push_data = '0;
    unique case (state)
      S_IDLE: cq_pop = head_ok;
      S_WAIT: begin
        rq_push      = wait_done;
        rq_push_to   = !br.dut_ready;
        rq_push_data = br.dut_ready ? br.dut_data : '0;
      end
      default: ;
    endcase
  end

  // Issue datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dut_cmd_q   <= '0;
      dut_wdata_q <= '0;
      hold_cnt    <= '0;
      wait_cnt    <= '0;
      cur_expect  <= 1'b0;
      reserved    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (cq_pop) begin
          dut_cmd_q   <= cq_cmd[cq_rd];
          dut_wdata_q <= cq_wdata[cq_rd];
          hold_cnt    <= HOLD_INIT;
          cur_expect  <= cq_exp[cq_rd];
          if (cq_exp[cq_rd]) reserved <= 1'b1;
        end
        S_ISSUE: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else begin
            dut_cmd_q <= '0;
            wait_cnt  <= '0;
          end
        end
        S_WAIT: begin
          if (rq_push) reserved <= 1'b0;
          else         wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // FIFO storage (not reset; validity is tracked by the counts)
  always_ff @(posedge clk) begin
    if (cq_push) begin
      cq_cmd[cq_wr]   <= br.in_cmd;
      cq_wdata[cq_wr] <= br.in_wdata;
      cq_exp[cq_wr]   <= br.in_expect;
    end
    if (rq_push) begin
      rq_data[rq_wr] <= rq_push_data;
      rq_to[rq_wr]   <= rq_push_to;
    end
  end

  // FIFO pointers and counts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cq_wr  <= '0;
      cq_rd  <= '0;
      cq_cnt <= '0;
      rq_wr  <= '0;
      rq_rd  <= '0;
      rq_cnt <= '0;
    end else begin
      if (cq_push) cq_wr <= cq_wr + CP_W'(1);
      if (cq_pop)  cq_rd <= cq_rd + CP_W'(1);
      if (cq_push && !cq_pop)      cq_cnt <= cq_cnt + (CP_W+1)'(1);
      else if (!cq_push && cq_pop) cq_cnt <= cq_cnt - (CP_W+1)'(1);

      if (rq_push) rq_wr <= rq_wr + RP_W'(1);
      if (rq_pop)  rq_rd <= rq_rd + RP_W'(1);
      if (rq_push && !rq_pop)      rq_cnt <= rq_cnt + (RP_W+1)'(1);
      else if (!rq_push && rq_pop) rq_cnt <= rq_cnt - (RP_W+1)'(1);
    end
  end

  assign br.in_ready     = !cq_full;
  assign br.dut_cmd      = dut_cmd_q;
  assign br.dut_wdata    = dut_wdata_q;
  assign br.resp_valid   = (rq_cnt != '0);
  assign br.resp_data    = (rq_cnt != '0) ? rq_data[rq_rd] : '0;
  assign br.resp_timeout = (rq_cnt != '0) ? rq_to[rq_rd] : 1'b0;
  assign br.busy         = (state != S_IDLE) || (cq_cnt != '0);

endmodule

// File: tb/tb_pwl_cmd_bridge.sv
module tb_pwl_cmd_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pwl_cmd_bridge_if #(.CMD_BITS(3), .DATA_BITS(13)) bus ();

  pwl_cmd_bridge #(
    .CMD_BITS(3), .DATA_BITS(13), .CMD_DEPTH(4), .RESP_DEPTH(4),
    .HOLD_CYCLES(1), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .br(bus)
  );

  always #5 clk = ~clk;

  // Pulse monitor: logs each nonzero dut_cmd pulse and flags wrong widths.
  logic [2:0]  prev_cmd = 3'd0;
  int          issued = 0;
  int          width = 0;
  int          width_err = 0;
  logic [2:0]  iss_cmd[$];
  logic [12:0] iss_wd[$];

  always @(negedge clk) begin
    if (bus.dut_cmd != 3'd0) begin
      if (prev_cmd == 3'd0) begin
        iss_cmd.push_back(bus.dut_cmd);
        iss_wd.push_back(bus.dut_wdata);
        issued = issued + 1;
        width = 1;
      end else begin
        width = width + 1;
      end
    end else if (prev_cmd != 3'd0 && width != 1) begin
      width_err = width_err + 1;
    end
    prev_cmd = bus.dut_cmd;
  end

  int accepted;
  int stall_at;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [12:0] d, input logic e);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_cmd    = c;
    bus.in_wdata  = d;
    bus.in_expect = e;
    n = 0;
    if (!bus.in_ready && stall_at < 0) stall_at = accepted;
    while (!bus.in_ready && n < 60) begin
      step();
      n++;
    end
    check("push_accept", 32'(bus.in_ready), 32'd1);
    step();
    accepted++;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_issued(input string tag, input int target);
    int n;
    n = 0;
    while (issued < target && n < 100) begin
      step();
      n++;
    end
    check(tag, 32'(issued), 32'(target));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_dut_cmd"},    32'(bus.dut_cmd),      32'd0);
    check({tag, "_dut_wdata"},  32'(bus.dut_wdata),    32'd0);
    check({tag, "_in_ready"},   32'(bus.in_ready),     32'd1);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid),   32'd0);
    check({tag, "_resp_data"},  32'(bus.resp_data),    32'd0);
    check({tag, "_resp_to"},    32'(bus.resp_timeout), 32'd0);
    check({tag, "_busy"},       32'(bus.busy),         32'd0);
  endtask

  initial begin
    int base;
    bus.in_valid   = 1'b0;
    bus.in_cmd     = '0;
    bus.in_wdata   = '0;
    bus.in_expect  = 1'b0;
    bus.dut_data   = '0;
    bus.dut_ready  = 1'b0;
    bus.resp_ready = 1'b0;
    accepted = 0;
    stall_at = -1;

    // Reset and idle
    step();
    step();
    rst_n = 1'b1;
    check_idle_outputs("reset");
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_dut_cmd", 32'(bus.dut_cmd), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_in_ready", 32'(bus.in_ready), 32'd1);
      check("idle_resp_valid", 32'(bus.resp_valid), 32'd0);
    end

    // No-expect command: one-cycle pulse, wdata held, no response
    push(3'd3, 13'h1ABC, 1'b0);
    check("t2_pre_cmd", 32'(bus.dut_cmd), 32'd0);
    check("t2_busy", 32'(bus.busy), 32'd1);
    step();
    check("t2_cmd", 32'(bus.dut_cmd), 32'd3);
    check("t2_wdata", 32'(bus.dut_wdata), 32'h1ABC);
    step();
    check("t2_nop", 32'(bus.dut_cmd), 32'd0);
    check("t2_wdata_held", 32'(bus.dut_wdata), 32'h1ABC);
    check("t2_busy_end", 32'(bus.busy), 32'd0);
    step();
    check("t2_no_resp", 32'(bus.resp_valid), 32'd0);

    // Expect command, ready on WAIT cycle 3
    push(3'd5, 13'h0042, 1'b1);
    step();
    check("t3_cmd", 32'(bus.dut_cmd), 32'd5);
    step();
    check("t3_nop", 32'(bus.dut_cmd), 32'd0);
    check("t3_busy", 32'(bus.busy), 32'd1);
    step();
    check("t3_w1_resp", 32'(bus.resp_valid), 32'd0);
    step();
    check("t3_w2_resp", 32'(bus.resp_valid), 32'd0);
    bus.dut_ready = 1'b1;
    bus.dut_data  = 13'h0123;
    step();
    bus.dut_ready = 1'b0;
    bus.dut_data  = 13'h0000;
    check("t3_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("t3_resp_data", 32'(bus.resp_data), 32'h0123);
    check("t3_resp_to", 32'(bus.resp_timeout), 32'd0);
    check("t3_busy_end", 32'(bus.busy), 32'd0);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("t3_single_resp", 32'(bus.resp_valid), 32'd0);

    // Timeout after 8 WAIT cycles
    push(3'd2, 13'h0002, 1'b1);
    step();
    check("t4_cmd", 32'(bus.dut_cmd), 32'd2);
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      check("t4_wait_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    step();
    check("t4_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("t4_resp_data", 32'(bus.resp_data), 32'd0);
    check("t4_resp_to", 32'(bus.resp_timeout), 32'd1);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    base = issued;
    push(3'd4, 13'h0777, 1'b0);
    wait_issued("t4_next_issued", base + 1);
    check("t4_next_cmd", 32'(iss_cmd[base]), 32'd4);
    check("t4_next_wdata", 32'(iss_wd[base]), 32'h0777);
    step();
    step();

    // Six commands; the first stalls on a timeout so the command FIFO fills
    base = issued;
    accepted = 0;
    stall_at = -1;
    push(3'd1, 13'h0101, 1'b1);
    for (int k = 2; k <= 6; k++) push(3'(k), 13'(16'h0100 + k), 1'b0);
    check("t5_stall_after", 32'(stall_at), 32'd5);
    wait_issued("t5_all_issued", base + 6);
    for (int k = 0; k < 6; k++) begin
      check("t5_order_cmd", 32'(iss_cmd[base + k]), 32'(k + 1));
      check("t5_order_wdata", 32'(iss_wd[base + k]), 32'(16'h0101 + k));
    end
    step();
    step();
    check("t5_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("t5_resp_to", 32'(bus.resp_timeout), 32'd1);
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("t5_resp_drained", 32'(bus.resp_valid), 32'd0);

    // Response FIFO back-pressure via reservation, then reset mid-WAIT
    base = issued;
    bus.dut_ready = 1'b1;
    bus.dut_data  = 13'h0555;
    for (int k = 1; k <= 5; k++) push(3'(k), 13'(16'h0200 + k), 1'b1);
    wait_issued("t6_four_issued", base + 4);
    for (int i = 0; i < 10; i++) step();
    check("t6_fifth_held", 32'(issued), 32'(base + 4));
    check("t6_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("t6_resp_data", 32'(bus.resp_data), 32'h0555);
    check("t6_resp_to", 32'(bus.resp_timeout), 32'd0);
    check("t6_busy", 32'(bus.busy), 32'd1);
    bus.dut_ready = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    wait_issued("t6_fifth_issued", base + 5);
    check("t6_fifth_cmd", 32'(iss_cmd[base + 4]), 32'd5);
    check("t6_fifth_wdata", 32'(iss_wd[base + 4]), 32'h0205);
    push(3'd7, 13'h0777, 1'b0);
    step();
    step();
    check("t6_busy_in_wait", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle_outputs("t6_reset");
    base = issued;
    for (int i = 0; i < 12; i++) step();
    check("t6_nothing_after_reset", 32'(issued), 32'(base));
    check("t6_no_resp_after_reset", 32'(bus.resp_valid), 32'd0);
    check("pulse_width_errors", 32'(width_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
